// File: rtl/sd_pkg.sv
// Shared encodings and constants for the SD command-line engine.
package sd_pkg;
  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_48   = 2'd1;
  localparam logic [1:0] RESP_136  = 2'd2;

  // x^7 + x^3 + 1, leading term implicit
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int INIT_CYCLES = 74;

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_SEND, ST_TURN, ST_WAIT_START, ST_RECV, ST_GAP
  } sd_state_e;

  typedef struct packed {
    logic [1:0] rtype;
    logic       crc_chk;
  } sd_req_t;
endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7, MSB-first; one bit folded in per enabled cycle.
module sd_crc7 import sd_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [6:0] crc
);
  logic fb;
  assign fb = bit_in ^ crc[6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   crc <= '0;
    else if (clr) crc <= '0;
    else if (en)  crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  end
endmodule

// File: rtl/sd_cmd_engine.sv
// SD/SDIO command-line engine: divided sd_clk, 48-bit command serialiser with CRC7,
// optional 48/136-bit response capture with CRC check and start-bit timeout.
module sd_cmd_engine import sd_pkg::*; #(
  parameter int CLK_DIV      = 34,
  parameter int RESP_TIMEOUT = 64,
  parameter int NRC_GAP      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  input  logic         resp_crc_chk,
  output logic         resp_valid,
  output logic [127:0] resp_data,
  output logic         resp_crc_err,
  output logic         resp_timeout,
  output logic         sd_clk,
  output logic         sd_cmd_o,
  output logic         sd_cmd_oe,
  input  logic         sd_cmd_i
);
  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);
  localparam logic [15:0] TO_LAST   = 16'(RESP_TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST  = 16'(NRC_GAP - 1);

  sd_state_e    state;
  sd_req_t      req;
  logic [15:0]  div_cnt, cnt, rx_len;
  logic [47:0]  tx_sr;
  logic [126:0] rx_sr;
  logic [127:0] rx_next;
  logic [6:0]   crc_tx, crc_rx;
  logic         wrap, rise, fall, accept, tx_bit, rx_last, rx_crc_bad;
  logic         tx_crc_en, rx_crc_clr, rx_crc_en;

  assign wrap       = (div_cnt == DIV_LAST);
  assign rise       = wrap && !sd_clk;
  assign fall       = wrap && sd_clk;
  assign accept     = cmd_valid && cmd_ready;
  assign rx_next    = {rx_sr, sd_cmd_i};
  assign rx_len     = (req.rtype == RESP_136) ? 16'd136 : 16'd48;
  assign rx_last    = (cnt == rx_len - 16'd1);
  assign rx_crc_bad = (crc_rx != rx_next[7:1]);
  assign tx_crc_en  = (state == ST_SEND) && fall && (cnt < 16'd40);
  assign rx_crc_clr = (state == ST_TURN);

  // Bits 47..8 come from the shift register, 7..1 from the running CRC, then the end bit.
  always_comb begin
    tx_bit = 1'b1;
    if (cnt < 16'd40)      tx_bit = tx_sr[47];
    else if (cnt < 16'd47) tx_bit = crc_tx[3'(16'd46 - cnt)];
  end

  // R2 CRC skips the start/transmission/reserved byte; the short response covers it.
  always_comb begin
    rx_crc_en = 1'b0;
    if (rise && state == ST_WAIT_START)
      rx_crc_en = !sd_cmd_i && (req.rtype == RESP_48);
    else if (rise && state == ST_RECV)
      rx_crc_en = (req.rtype == RESP_136) ? (cnt >= 16'd8 && cnt < 16'd128) : (cnt < 16'd40);
  end

  sd_crc7 u_crc_tx (.clk(clk), .rst_n(rst_n), .clr(accept), .en(tx_crc_en),
                    .bit_in(tx_sr[47]), .crc(crc_tx));
  sd_crc7 u_crc_rx (.clk(clk), .rst_n(rst_n), .clr(rx_crc_clr), .en(rx_crc_en),
                    .bit_in(sd_cmd_i), .crc(crc_rx));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_INIT;
      req          <= '0;
      div_cnt      <= '0;
      cnt          <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      sd_clk       <= 1'b0;
      sd_cmd_o     <= 1'b1;
      sd_cmd_oe    <= 1'b0;
      cmd_ready    <= 1'b0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_crc_err <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      div_cnt    <= wrap ? '0 : div_cnt + 16'd1;
      if (wrap) sd_clk <= !sd_clk;

      case (state)
        ST_INIT: if (rise) begin
          if (cnt == INIT_LAST) begin
            cnt       <= '0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end else cnt <= cnt + 16'd1;
        end

        ST_IDLE: if (accept) begin
          cmd_ready   <= 1'b0;
          req.rtype   <= (resp_type == 2'd3) ? RESP_NONE : resp_type;
          req.crc_chk <= resp_crc_chk;
          tx_sr       <= {2'b01, cmd_index, cmd_arg, 8'hFF};
          cnt         <= '0;
          state       <= ST_SEND;
        end

        ST_SEND: begin
          if (fall && cnt < 16'd48) begin
            sd_cmd_oe <= 1'b1;
            sd_cmd_o  <= tx_bit;
            tx_sr     <= {tx_sr[46:0], 1'b0};
            cnt       <= cnt + 16'd1;
          end else if (rise && cnt == 16'd48) begin
            cnt   <= '0;
            state <= ST_TURN;
          end
        end

        ST_TURN: if (fall) begin
          sd_cmd_oe <= 1'b0;
          sd_cmd_o  <= 1'b1;
          cnt       <= '0;
          state     <= (req.rtype == RESP_NONE) ? ST_GAP : ST_WAIT_START;
        end

        // Start bit wins over timeout when both land on the same rise tick.
        ST_WAIT_START: if (rise) begin
          if (!sd_cmd_i) begin
            rx_sr <= rx_next[126:0];
            cnt   <= 16'd1;
            state <= ST_RECV;
          end else if (cnt == TO_LAST) begin
            resp_valid   <= 1'b1;
            resp_timeout <= 1'b1;
            resp_crc_err <= 1'b0;
            cnt          <= '0;
            state        <= ST_GAP;
          end else cnt <= cnt + 16'd1;
        end

        ST_RECV: if (rise) begin
          rx_sr <= rx_next[126:0];
          if (rx_last) begin
            resp_valid   <= 1'b1;
            resp_timeout <= 1'b0;
            resp_crc_err <= req.crc_chk && rx_crc_bad;
            resp_data    <= (req.rtype == RESP_136) ? rx_next : {90'b0, rx_next[45:8]};
            cnt          <= '0;
            state        <= ST_GAP;
          end else cnt <= cnt + 16'd1;
        end

        ST_GAP: if (rise) begin
          if (cnt == GAP_LAST) begin
            cnt       <= '0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end else cnt <= cnt + 16'd1;
        end

        default: state <= ST_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_cmd_engine.sv
// Scoreboard bench for sd_cmd_engine: stimulus queues expected frames/responses,
// independent monitors on the cmd line and on resp_valid pop and compare.
module tb_sd_cmd_engine;
  import sd_pkg::*;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         cmd_valid = 1'b0, cmd_ready;
  logic [5:0]   cmd_index = '0;
  logic [31:0]  cmd_arg = '0;
  logic [1:0]   resp_type = '0;
  logic         resp_crc_chk = 1'b0;
  logic         resp_valid, resp_crc_err, resp_timeout;
  logic [127:0] resp_data;
  logic         sd_clk, sd_cmd_o, sd_cmd_oe;
  logic         sd_cmd_i = 1'b1;

  always #5 clk = ~clk;

  sd_cmd_engine #(.CLK_DIV(3), .RESP_TIMEOUT(64), .NRC_GAP(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .resp_type(resp_type),
    .resp_crc_chk(resp_crc_chk), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_crc_err(resp_crc_err), .resp_timeout(resp_timeout), .sd_clk(sd_clk),
    .sd_cmd_o(sd_cmd_o), .sd_cmd_oe(sd_cmd_oe), .sd_cmd_i(sd_cmd_i)
  );

  typedef struct {
    logic [127:0] data;
    logic         crc_err;
    logic         timeout;
    logic         chk_data;
  } exp_t;

  exp_t        exp_q[$];
  logic [47:0] frame_q[$];
  int total = 0, bad = 0, n_resp = 0, exp_resp = 0, n_frames = 0, exp_frames = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, want);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin : resp_mon
    exp_t e;
    if (rst_n && resp_valid) begin
      n_resp++;
      check1("resp_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.chk_data) check("resp_data", resp_data, e.data);
        check1("resp_crc_err", resp_crc_err, e.crc_err);
        check1("resp_timeout", resp_timeout, e.timeout);
      end
    end
  end

  // Cmd-line monitor: the card samples on sd_clk rising edges.
  logic [47:0] cap = '0;
  int          nbits = 0;
  always @(posedge sd_clk) begin
    #1;
    if (!sd_cmd_oe) nbits = 0;
    else begin
      cap = {cap[46:0], sd_cmd_o};
      nbits++;
      if (nbits == 48) begin
        nbits = 0;
        n_frames++;
        check1("frame_expected", frame_q.size() != 0, 1'b1);
        if (frame_q.size() != 0) check("cmd_frame", 128'(cap), 128'(frame_q.pop_front()));
      end
    end
  end

  task automatic expect_resp(input logic [127:0] d, input logic ce, input logic to, input logic cd);
    exp_t e;
    e.data = d; e.crc_err = ce; e.timeout = to; e.chk_data = cd;
    exp_q.push_back(e);
    exp_resp++;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check1("ready_wait", cmd_ready, 1'b1);
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                       input logic chk, input logic push, input logic [47:0] frame);
    wait_ready();
    if (push) begin
      frame_q.push_back(frame);
      exp_frames++;
    end
    cmd_index = idx; cmd_arg = arg; resp_type = rt; resp_crc_chk = chk; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_index = '0; cmd_arg = '0; resp_type = '0; resp_crc_chk = 1'b0;
    check1("ready_drop", cmd_ready, 1'b0);
  endtask

  // Card model: drives each bit on an sd_clk fall, starting `delay` falls after release.
  task automatic card_respond(input logic [135:0] bits, input int n, input int delay);
    @(negedge sd_cmd_oe);
    repeat (delay) @(negedge sd_clk);
    for (int i = n - 1; i >= 1; i--) begin
      sd_cmd_i = bits[i];
      @(negedge sd_clk);
    end
    sd_cmd_i = bits[0];
    @(posedge sd_clk);
    @(negedge clk);
    check1("resp_at_last_rise", resp_valid, 1'b1);
    @(negedge sd_clk);
    sd_cmd_i = 1'b1;
  endtask

  task automatic check_gap_ready();
    repeat (7) @(posedge sd_clk);
    @(negedge clk);
    check1("gap_ready_early", cmd_ready, 1'b0);
    @(posedge sd_clk);
    @(negedge clk);
    check1("gap_ready", cmd_ready, 1'b1);
  endtask

  task automatic check_init();
    repeat (73) @(posedge sd_clk);
    @(negedge clk);
    check1("init_ready_early", cmd_ready, 1'b0);
    @(posedge sd_clk);
    @(negedge clk);
    check1("init_ready", cmd_ready, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_sd_clk"}, sd_clk, 1'b0);
    check1({tag, "_oe"}, sd_cmd_oe, 1'b0);
    check1({tag, "_cmd_o"}, sd_cmd_o, 1'b1);
    check1({tag, "_ready"}, cmd_ready, 1'b0);
    check1({tag, "_valid"}, resp_valid, 1'b0);
    check({tag, "_data"}, resp_data, 128'h0);
    check1({tag, "_crc_err"}, resp_crc_err, 1'b0);
    check1({tag, "_timeout"}, resp_timeout, 1'b0);
  endtask

  function automatic logic [6:0] crc7_model(input logic [119:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  logic [119:0] cid;
  logic [135:0] r2;

  initial begin
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    check_init();

    // CMD0, no response; gap measured from release of the line
    issue(6'd0, 32'h0, RESP_NONE, 1'b0, 1'b1, 48'h400000000095);
    @(negedge sd_cmd_oe);
    check_gap_ready();

    // CMD8 with a good R7
    expect_resp(128'h08000001AA, 1'b0, 1'b0, 1'b1);
    issue(6'd8, 32'h000001AA, RESP_48, 1'b1, 1'b1, 48'h48000001AA87);
    card_respond(136'h08000001AA13, 48, 2);

    // CRC7 field replaced by 0x12 -> last byte {0x12,1} = 0x25
    expect_resp(128'h08000001AA, 1'b1, 1'b0, 1'b1);
    issue(6'd8, 32'h000001AA, RESP_48, 1'b1, 1'b1, 48'h48000001AA87);
    card_respond(136'h08000001AA25, 48, 5);

    expect_resp(128'h08000001AA, 1'b0, 1'b0, 1'b1);
    issue(6'd8, 32'h000001AA, RESP_48, 1'b0, 1'b1, 48'h48000001AA87);
    card_respond(136'h08000001AA25, 48, 3);

    // CMD2 with a 136-bit R2
    cid = 120'h1D4144534430312010A1B2C3D4E5F6;
    r2  = {8'h3F, cid, crc7_model(cid), 1'b1};
    expect_resp(r2[127:0], 1'b0, 1'b0, 1'b1);
    issue(6'd2, 32'h0, RESP_136, 1'b1, 1'b1, 48'h42000000004D);
    card_respond(r2, 136, 4);

    // CMD55 with no card response: timeout lands on the 64th rise tick
    expect_resp(128'h0, 1'b0, 1'b1, 1'b0);
    issue(6'd55, 32'h0, RESP_48, 1'b1, 1'b1, 48'h770000000065);
    @(negedge sd_cmd_oe);
    repeat (63) @(posedge sd_clk);
    @(negedge clk);
    check1("timeout_early", resp_valid, 1'b0);
    @(posedge sd_clk);
    @(negedge clk);
    check1("timeout_edge", resp_valid, 1'b1);
    check_gap_ready();

    // Reset in the middle of SEND
    issue(6'd17, 32'h12345678, RESP_48, 1'b1, 1'b0, 48'h0);
    @(posedge sd_cmd_oe);
    repeat (19) @(negedge sd_clk);
    @(posedge sd_clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    #40;
    @(negedge clk);
    rst_n = 1'b1;
    check_init();

    // Reserved response type behaves as none
    issue(6'd0, 32'h0, 2'd3, 1'b1, 1'b1, 48'h400000000095);
    @(negedge sd_cmd_oe);
    check_gap_ready();

    repeat (20) @(negedge clk);
    check("resp_count", 128'(n_resp), 128'(exp_resp));
    check("frame_count", 128'(n_frames), 128'(exp_frames));
    check("resp_q_left", 128'(exp_q.size()), 128'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: got time limit reached want test end");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
